// File: rtl/memcore_pkg.sv
// Shared types and helpers for the lane-masked single-port RAM macro.
package memcore_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_e;

    // Lane width, or 0 when the word does not split evenly into lanes.
    function automatic int lane_w(input int data_w, input int mask_w);
        if ((mask_w <= 0) || ((data_w % mask_w) != 0)) begin
            return 0;
        end else begin
            return data_w / mask_w;
        end
    endfunction

endpackage

// File: rtl/memcore_init_seq.sv
// Init sequencer: walks every word address once with a write strobe,
// after reset release or on init_req, and gates user access meanwhile.
module memcore_init_seq
    import memcore_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int INIT_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_req,
    output logic              init_we,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_busy,
    output logic              ready
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam state_e RST_STATE = (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;

    state_e            state_r;
    state_e            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nxt_s;

    // Next-state and counter logic; the last index is compared explicitly so the counter never wraps into a second pass.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (init_req) begin
                    state_nxt_s = ST_INIT;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_INIT: begin
                if (cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_INIT;
                    cnt_nxt_s   = cnt_r + ADDR_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State and address counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RST_STATE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign init_we   = (state_r == ST_INIT);
    assign init_addr = cnt_r;
    assign init_busy = (state_r == ST_INIT);
    assign ready     = (state_r == ST_IDLE);

endmodule

// File: rtl/memcore_ram_init.sv
// Single-port lane-masked RAM with hardware init fill and an optional
// output register; read data is held and qualified by a valid pulse.
module memcore_ram_init
    import memcore_pkg::*;
#(
    parameter int                ADDR_W        = 10,
    parameter int                DATA_W        = 128,
    parameter int                MASK_W        = 16,
    parameter int                OUT_REG       = 0,
    parameter int                INIT_ON_RESET = 1,
    parameter logic [DATA_W-1:0] INIT_VALUE    = '0
) (
    input  logic              RW0_clk,
    input  logic              RW0_rst_n,
    input  logic              RW0_en,
    input  logic              RW0_wmode,
    input  logic [ADDR_W-1:0] RW0_addr,
    input  logic [MASK_W-1:0] RW0_wmask,
    input  logic [DATA_W-1:0] RW0_wdata,
    output logic [DATA_W-1:0] RW0_rdata,
    output logic              RW0_rvalid,
    output logic              RW0_ready,
    input  logic              init_req,
    output logic              init_busy
);

    localparam int LANE_W = lane_w(DATA_W, MASK_W);
    localparam int DEPTH  = 1 << ADDR_W;

    if (LANE_W == 0) begin : g_bad_mask
        $error("memcore_ram_init: DATA_W must be a multiple of MASK_W");
    end

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic              init_we_s;
    logic [ADDR_W-1:0] init_addr_s;
    logic              ready_s;
    logic              wr_s;
    logic              rd_s;
    logic              rd_vld_s1_r;
    logic [DATA_W-1:0] rd_data_s1_r;

    memcore_init_seq #(
        .ADDR_W        (ADDR_W),
        .INIT_ON_RESET (INIT_ON_RESET)
    ) u_init_seq (
        .clk       (RW0_clk),
        .rst_n     (RW0_rst_n),
        .init_req  (init_req),
        .init_we   (init_we_s),
        .init_addr (init_addr_s),
        .init_busy (init_busy),
        .ready     (ready_s)
    );

    // Requests while the sequencer owns the array are dropped outright.
    assign wr_s      = RW0_en && ready_s && RW0_wmode;
    assign rd_s      = RW0_en && ready_s && !RW0_wmode;
    assign RW0_ready = ready_s;

    // Storage write port: the init fill and user writes never overlap since ready is low during init.
    always_ff @(posedge RW0_clk) begin
        if (init_we_s) begin
            mem_r[init_addr_s] <= INIT_VALUE;
        end else if (wr_s) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (RW0_wmask[i]) begin
                    mem_r[RW0_addr][i*LANE_W +: LANE_W] <= RW0_wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // First read stage: data only reloads on an accepted read so it holds between reads.
    always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
        if (!RW0_rst_n) begin
            rd_vld_s1_r  <= 1'b0;
            rd_data_s1_r <= '0;
        end else begin
            rd_vld_s1_r <= rd_s;
            if (rd_s) begin
                rd_data_s1_r <= mem_r[RW0_addr];
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic              out_vld_r;
        logic [DATA_W-1:0] out_data_r;

        // Second read stage, loaded only when stage one carries a result.
        always_ff @(posedge RW0_clk or negedge RW0_rst_n) begin
            if (!RW0_rst_n) begin
                out_vld_r  <= 1'b0;
                out_data_r <= '0;
            end else begin
                out_vld_r <= rd_vld_s1_r;
                if (rd_vld_s1_r) begin
                    out_data_r <= rd_data_s1_r;
                end
            end
        end

        assign RW0_rdata  = out_data_r;
        assign RW0_rvalid = out_vld_r;
    end else begin : g_no_out_reg
        assign RW0_rdata  = rd_data_s1_r;
        assign RW0_rvalid = rd_vld_s1_r;
    end

endmodule

// File: tb/tb_memcore_ram_init.sv
// Bench: two instances (OUT_REG=0/init on reset, OUT_REG=1/no init on reset)
// share one stimulus stream and are compared every cycle against a model.
module tb_memcore_ram_init;

    localparam int          DEPTH = 16;
    localparam logic [31:0] IV    = 32'hA5A5A5A5;

    typedef struct {
        int          inst;
        logic [31:0] data;
        bit          known;
        int          due;
    } rd_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        wmode = 1'b0;
    logic        init_req = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [3:0]  wmask = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata_s [2];
    logic        rvalid_s [2];
    logic        ready_s [2];
    logic        busy_s [2];

    logic [31:0] mem_m [2][DEPTH];
    bit          known_m [2][DEPTH];
    int          busy_m [2];
    logic [31:0] rdata_m [2];
    bit          rvalid_m [2];
    bit          rk_m [2];
    rd_t         q [$];
    int          ecount = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] sweep [DEPTH];

    always #5 clk = ~clk;

    memcore_ram_init #(
        .ADDR_W(4), .DATA_W(32), .MASK_W(4), .OUT_REG(0),
        .INIT_ON_RESET(1), .INIT_VALUE(32'hA5A5A5A5)
    ) u_dut0 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_addr(addr), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_rdata(rdata_s[0]), .RW0_rvalid(rvalid_s[0]), .RW0_ready(ready_s[0]),
        .init_req(init_req), .init_busy(busy_s[0])
    );

    memcore_ram_init #(
        .ADDR_W(4), .DATA_W(32), .MASK_W(4), .OUT_REG(1),
        .INIT_ON_RESET(0), .INIT_VALUE(32'hA5A5A5A5)
    ) u_dut1 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_en(en), .RW0_wmode(wmode),
        .RW0_addr(addr), .RW0_wmask(wmask), .RW0_wdata(wdata),
        .RW0_rdata(rdata_s[1]), .RW0_rvalid(rvalid_s[1]), .RW0_ready(ready_s[1]),
        .init_req(init_req), .init_busy(busy_s[1])
    );

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic bit init_on(input int d);
        return (d == 0);
    endfunction

    task automatic fill_init(input int d);
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[d][a]   = IV;
            known_m[d][a] = 1'b1;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            busy_m[d]   = init_on(d) ? DEPTH : 0;
            rdata_m[d]  = 32'd0;
            rvalid_m[d] = 1'b0;
            rk_m[d]     = 1'b1;
            if (init_on(d)) fill_init(d);
        end
        q.delete();
    endtask

    // One clock edge of the abstract model, using the inputs that edge samples.
    task automatic model_edge();
        ecount++;
        for (int d = 0; d < 2; d++) begin
            bit rdy;
            int idx;
            rd_t r;
            rdy = (busy_m[d] == 0);
            if (en && rdy) begin
                if (wmode) begin
                    for (int l = 0; l < 4; l++)
                        if (wmask[l]) mem_m[d][addr][l*8 +: 8] = wdata[l*8 +: 8];
                    known_m[d][addr] = known_m[d][addr] || (wmask == 4'hF);
                end else begin
                    r.inst  = d;
                    r.data  = mem_m[d][addr];
                    r.known = known_m[d][addr];
                    r.due   = ecount + lat(d) - 1;
                    q.push_back(r);
                end
            end
            if (init_req && rdy) begin
                busy_m[d] = DEPTH;
                fill_init(d);
            end else if (busy_m[d] > 0) begin
                busy_m[d]--;
            end
            rvalid_m[d] = 1'b0;
            idx = -1;
            for (int i = 0; i < q.size(); i++)
                if (q[i].inst == d && q[i].due == ecount) idx = i;
            if (idx >= 0) begin
                rvalid_m[d] = 1'b1;
                rdata_m[d]  = q[idx].data;
                rk_m[d]     = q[idx].known;
                q.delete(idx);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d ready", d), 32'(ready_s[d]), 32'(busy_m[d] == 0));
            chk($sformatf("dut%0d init_busy", d), 32'(busy_s[d]), 32'(busy_m[d] != 0));
            chk($sformatf("dut%0d rvalid", d), 32'(rvalid_s[d]), 32'(rvalid_m[d]));
            if (rk_m[d]) chk($sformatf("dut%0d rdata", d), rdata_s[d], rdata_m[d]);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        en = 1'b0; wmode = 1'b0; init_req = 1'b0; wmask = 4'd0;
    endtask

    task automatic access(input bit wr, input logic [3:0] a, input logic [3:0] m, input logic [31:0] dat);
        en = 1'b1; wmode = wr; addr = a; wmask = m; wdata = dat;
        cycle();
        idle_inputs();
    endtask

    // Counts post-edge samples with dut0 busy; optional init_req pulse at sample inj.
    task automatic measure_busy(input int inj, output int n);
        n = 0;
        while (busy_s[0] && n < 100) begin
            n++;
            init_req = (n == inj);
            cycle();
            init_req = 1'b0;
        end
    endtask

    initial begin
        int n;
        idle_inputs();
        #2 rst_n = 1'b0;
        model_reset();
        #1 compare_all();
        repeat (3) cycle();
        rst_n = 1'b1;
        #1;
        // INIT_ON_RESET=0 instance is ready at once, the other is busy.
        chk("t7 dut1 ready after release", 32'(ready_s[1]), 32'd1);
        chk("t7 dut1 busy after release", 32'(busy_s[1]), 32'd0);
        chk("t1 dut0 ready after release", 32'(ready_s[0]), 32'd0);

        measure_busy(0, n);
        chk("t1 busy cycles", 32'(n), 32'd16);
        access(1'b0, 4'd5, 4'h0, 32'd0);
        chk("t1 read5 rvalid", 32'(rvalid_s[0]), 32'd1);
        chk("t1 read5 rdata", rdata_s[0], IV);
        cycle();

        for (int i = 0; i < DEPTH; i++) begin
            sweep[i] = $urandom;
            access(1'b1, 4'(i), 4'hF, sweep[i]);
        end

        access(1'b1, 4'd3, 4'hF, 32'hDEADBEEF);
        access(1'b1, 4'd3, 4'h5, 32'h11223344);
        access(1'b0, 4'd3, 4'h0, 32'd0);
        chk("t2 dut0 masked read", rdata_s[0], 32'hDE22BE44);
        cycle();
        chk("t2 dut1 masked read", rdata_s[1], 32'hDE22BE44);
        cycle();

        access(1'b0, 4'd1, 4'h0, 32'd0);
        chk("t3 dut1 no early rvalid", 32'(rvalid_s[1]), 32'd0);
        access(1'b0, 4'd2, 4'h0, 32'd0);
        chk("t3 dut1 addr1 rvalid", 32'(rvalid_s[1]), 32'd1);
        chk("t3 dut1 addr1 rdata", rdata_s[1], sweep[1]);
        access(1'b0, 4'd3, 4'h0, 32'd0);
        chk("t3 dut1 addr2 rdata", rdata_s[1], sweep[2]);
        cycle();
        chk("t3 dut1 addr3 rdata", rdata_s[1], 32'hDE22BE44);
        cycle();
        chk("t3 dut1 rvalid low after", 32'(rvalid_s[1]), 32'd0);
        chk("t3 dut1 rdata held", rdata_s[1], 32'hDE22BE44);

        init_req = 1'b1;
        access(1'b1, 4'd7, 4'hF, 32'h12345678);
        measure_busy(6, n);
        chk("t4 busy cycles with second req", 32'(n), 32'd16);
        access(1'b0, 4'd7, 4'h0, 32'd0);
        chk("t4 dut0 read7", rdata_s[0], IV);
        cycle();
        chk("t4 dut1 read7", rdata_s[1], IV);

        init_req = 1'b1;
        cycle();
        init_req = 1'b0;
        repeat (9) cycle();
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("t5 rdata cleared", rdata_s[0], 32'd0);
        chk("t5 rvalid cleared", 32'(rvalid_s[0]), 32'd0);
        chk("t5 ready low", 32'(ready_s[0]), 32'd0);
        repeat (2) cycle();
        rst_n = 1'b1;

        access(1'b1, 4'd2, 4'hF, 32'h0BADF00D);
        chk("t6 no rvalid on dropped write", 32'(rvalid_s[0]), 32'd0);
        measure_busy(0, n);
        chk("t5 busy cycles after mid-init reset", 32'(n + 1), 32'd16);
        access(1'b0, 4'd2, 4'h0, 32'd0);
        chk("t6 dut0 read2", rdata_s[0], IV);
        cycle();
        chk("t6 dut1 read2", rdata_s[1], 32'h0BADF00D);

        repeat (400) begin
            en       = ($urandom_range(0, 9) < 7);
            wmode    = 1'($urandom_range(0, 1));
            addr     = 4'($urandom);
            wmask    = 4'($urandom);
            wdata    = $urandom;
            init_req = ($urandom_range(0, 63) == 0);
            cycle();
        end
        idle_inputs();
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
